// File: rtl/count_pkg.sv
// Shared types and constants for the counter-tile checker: FSM encoding,
// saturation limits and small helpers used by the top and its comparator.
package count_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_TURN  = 3'd2,
    ST_SYNC  = 3'd3,
    ST_TRACK = 3'd4
  } state_e;

  localparam logic [3:0] SEED_LSB  = 4'h0;
  localparam logic [6:0] ERR_MAX   = 7'd127;
  localparam logic [3:0] MATCH_MAX = 4'd15;

  // Saturating increment for the 7-bit error counter (never wraps to zero).
  function automatic logic [6:0] sat_inc_err(input logic [6:0] value);
    logic [6:0] result;
    if (value == ERR_MAX) begin
      result = value;
    end else begin
      result = value + 7'd1;
    end
    return result;
  endfunction

  // Status view layout: {state, locked, mismatch_now, wrap_seen, 0}.
  function automatic logic [6:0] status_byte(input state_e st, input logic locked,
                                             input logic mismatch_now, input logic wrap_seen);
    return {st, locked, mismatch_now, wrap_seen, 1'b0};
  endfunction

endpackage

// File: rtl/count_seq_compare.sv
// Sequence comparator: tracks the expected next counter value, decides
// match/mismatch per sample, and maintains the match run and lock flag.
module count_seq_compare #(
  parameter int LOCK_COUNT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       sync,
  input  logic       restart,
  input  logic [7:0] sample,
  output logic       match,
  output logic       mismatch,
  output logic       locked,
  output logic       wrap
);
  import count_pkg::*;

  localparam logic [4:0] LOCK_TH = 5'(LOCK_COUNT);

  logic [7:0] expected_q, expected_d;
  logic [3:0] match_run_q, match_run_d;
  logic       locked_q, locked_d;
  logic [4:0] run_plus1;

  // Expected always holds previous sample + 1, so a match on 8'h00 means the prior sample was 8'hFF.
  always_comb begin
    match       = enable && (sample == expected_q);
    mismatch    = enable && (sample != expected_q);
    wrap        = match && (sample == 8'h00);
    run_plus1   = {1'b0, match_run_q} + 5'd1;
    expected_d  = expected_q;
    match_run_d = match_run_q;
    locked_d    = locked_q;
    if (restart) begin
      match_run_d = 4'd0;
      locked_d    = 1'b0;
    end else if (sync) begin
      expected_d = sample + 8'd1;
    end else if (match) begin
      expected_d = expected_q + 8'd1;
      if (match_run_q != MATCH_MAX) begin
        match_run_d = match_run_q + 4'd1;
      end else begin
        match_run_d = match_run_q;
      end
      if (run_plus1 >= LOCK_TH) begin
        locked_d = 1'b1;
      end else begin
        locked_d = locked_q;
      end
    end else if (mismatch) begin
      expected_d  = sample + 8'd1;
      match_run_d = 4'd0;
      locked_d    = 1'b0;
    end else begin
      expected_d = expected_q;
    end
  end

  // Comparator state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      expected_q  <= 8'h00;
      match_run_q <= 4'd0;
      locked_q    <= 1'b0;
    end else begin
      expected_q  <= expected_d;
      match_run_q <= match_run_d;
      locked_q    <= locked_d;
    end
  end

  assign locked = locked_q;

endmodule

// File: rtl/tt_um_count_checker.sv
// Peer checker for the 8-bit loadable counter tile: loads a seed over uio,
// then verifies the returned stream increments by one every cycle.
module tt_um_count_checker #(
  parameter int LOCK_COUNT = 4,
  parameter int ERR_W      = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  import count_pkg::*;

  state_e           state_q, state_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             wrap_seen_q, wrap_seen_d;
  logic             mismatch_now_q, mismatch_now_d;
  logic             load_q, load_d;

  logic       start, clear, view_sel, stop;
  logic [7:0] seed;
  logic       seq_match, seq_mismatch, seq_locked, seq_wrap;
  logic       unused_sink;

  assign start    = ui_in[0];
  assign clear    = ui_in[1];
  assign view_sel = ui_in[2];
  assign stop     = ui_in[3];
  assign seed     = {ui_in[7:4], SEED_LSB};

  assign unused_sink = &{1'b0, ena, seq_match};

  count_seq_compare #(
    .LOCK_COUNT(LOCK_COUNT)
  ) u_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (state_q == ST_TRACK),
    .sync     (state_q == ST_SYNC),
    .restart  (state_q == ST_LOAD),
    .sample   (uio_in),
    .match    (seq_match),
    .mismatch (seq_mismatch),
    .locked   (seq_locked),
    .wrap     (seq_wrap)
  );

  // Next state: stop beats start, and start restarts from any state.
  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = ST_IDLE;
    end else if (start) begin
      state_d = ST_LOAD;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = ST_IDLE;
        ST_LOAD:  state_d = ST_TURN;
        ST_TURN:  state_d = ST_SYNC;
        ST_SYNC:  state_d = ST_TRACK;
        ST_TRACK: state_d = ST_TRACK;
        default:  state_d = ST_IDLE;
      endcase
    end
    load_d = (state_d == ST_LOAD);
  end

  // Error count and sticky wrap flag; clear wins over a same-cycle event.
  always_comb begin
    err_cnt_d      = err_cnt_q;
    wrap_seen_d    = wrap_seen_q;
    mismatch_now_d = seq_mismatch;
    if (clear) begin
      err_cnt_d   = '0;
      wrap_seen_d = 1'b0;
    end else begin
      if (seq_mismatch) begin
        err_cnt_d = sat_inc_err(err_cnt_q);
      end else begin
        err_cnt_d = err_cnt_q;
      end
      if (seq_wrap) begin
        wrap_seen_d = 1'b1;
      end else begin
        wrap_seen_d = wrap_seen_q;
      end
    end
  end

  // Control and status registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      err_cnt_q      <= '0;
      wrap_seen_q    <= 1'b0;
      mismatch_now_q <= 1'b0;
      load_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      err_cnt_q      <= err_cnt_d;
      wrap_seen_q    <= wrap_seen_d;
      mismatch_now_q <= mismatch_now_d;
      load_q         <= load_d;
    end
  end

  // Output muxes; the bus is only driven while the load strobe is up.
  always_comb begin
    if (view_sel) begin
      uo_out = {load_q, status_byte(state_q, seq_locked, mismatch_now_q, wrap_seen_q)};
    end else begin
      uo_out = {load_q, err_cnt_q};
    end
    if (load_q) begin
      uio_oe  = 8'hFF;
      uio_out = seed;
    end else begin
      uio_oe  = 8'h00;
      uio_out = 8'h00;
    end
  end

endmodule

// File: tb/tb_tt_um_count_checker.sv
// Self-checking bench: directed bring-up scenarios plus a randomized run,
// all compared every cycle against a sequence-level reference model.
module tb_tt_um_count_checker;

  localparam int LOCK_COUNT = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks   = 0;
  int failures = 0;

  tt_um_count_checker #(.LOCK_COUNT(LOCK_COUNT), .ERR_W(7)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0..4 = idle/load/turn/sync/track, last sample, run length.
  int         m_state = 0;
  int         m_err   = 0;
  int         m_run   = 0;
  logic [7:0] m_last  = 8'hFF;
  logic [7:0] m_nxt;
  bit         m_wrap  = 1'b0;
  bit         m_mism  = 1'b0;
  bit         m_valid = 1'b0;

  assign m_nxt = m_last + 8'd1;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_state <= 0;
      m_err   <= 0;
      m_run   <= 0;
      m_last  <= 8'hFF;
      m_wrap  <= 1'b0;
      m_mism  <= 1'b0;
      m_valid <= 1'b1;
    end else begin
      if (m_state == 4) begin
        if (uio_in == m_nxt) begin
          m_run  <= m_run + 1;
          m_mism <= 1'b0;
          if (m_last == 8'hFF && uio_in == 8'h00) m_wrap <= 1'b1;
        end else begin
          m_run  <= 0;
          m_mism <= 1'b1;
          m_err  <= (m_err < 127) ? m_err + 1 : 127;
        end
        m_last <= uio_in;
      end else begin
        m_mism <= 1'b0;
      end
      if (m_state == 3) m_last <= uio_in;
      if (m_state == 1) m_run <= 0;
      if (ui_in[1]) begin
        m_err  <= 0;
        m_wrap <= 1'b0;
      end
      if (ui_in[3])                       m_state <= 0;
      else if (ui_in[0])                  m_state <= 1;
      else if (m_state >= 1 && m_state <= 3) m_state <= m_state + 1;
      else                                m_state <= m_state;
    end
  end

  logic       e_load;
  logic [6:0] e_view;
  logic [7:0] e_oe, e_out;

  // Compare process: mid-cycle, after registers and inputs have settled.
  always @(negedge clk) begin
    if (m_valid) begin
      e_load = (m_state == 1);
      e_oe   = e_load ? 8'hFF : 8'h00;
      e_out  = e_load ? {ui_in[7:4], 4'h0} : 8'h00;
      e_view = ui_in[2] ? {3'(m_state), (m_run >= LOCK_COUNT), m_mism, m_wrap, 1'b0}
                        : 7'(m_err);
      check("model_uo_out", {24'h0, uo_out}, {24'h0, e_load, e_view});
      check("model_uio_oe", {24'h0, uio_oe}, {24'h0, e_oe});
      check("model_uio_out", {24'h0, uio_out}, {24'h0, e_out});
    end
  end

  logic [3:0] seed_n;

  // One cycle: ctl = {stop, view, clear, start}; returns 2 time units after the edge.
  task automatic tk(input logic [7:0] v, input logic [3:0] ctl);
    ui_in  = {seed_n, ctl};
    uio_in = v;
    @(posedge clk);
    #2;
  endtask

  logic [7:0] ctr;
  logic [3:0] ctl;
  int         r;

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    seed_n = 4'hA;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    tk(8'h00, 4'h0);
    tk(8'h00, 4'h0);
    check("reset_uo_out", {24'h0, uo_out}, 32'h0);
    check("reset_uio_oe", {24'h0, uio_oe}, 32'h0);
    check("reset_uio_out", {24'h0, uio_out}, 32'h0);
    rst_n = 1'b1;

    // Load seed A0 and lock onto A1..A4.
    tk(8'h00, 4'h1);
    check("load_uio_oe", {24'h0, uio_oe}, 32'hFF);
    check("load_uio_out", {24'h0, uio_out}, 32'hA0);
    check("load_strobe", {31'h0, uo_out[7]}, 32'h1);
    tk(8'h00, 4'h0);
    check("turn_uio_oe", {24'h0, uio_oe}, 32'h0);
    check("turn_strobe", {31'h0, uo_out[7]}, 32'h0);
    tk(8'h00, 4'h0);
    tk(8'hA0, 4'h0);
    tk(8'hA1, 4'h0);
    tk(8'hA2, 4'h0);
    tk(8'hA3, 4'h0);
    tk(8'hA4, 4'h4);
    check("locked_status", {24'h0, uo_out}, 32'h48);

    // Single corruption at 55 costs two errors, then relock.
    tk(8'h10, 4'h2);
    tk(8'h11, 4'h0);
    tk(8'h55, 4'h4);
    check("corrupt_status", {24'h0, uo_out}, 32'h44);
    tk(8'h13, 4'h0);
    tk(8'h14, 4'h0);
    check("corrupt_err2", {24'h0, uo_out}, 32'h02);
    tk(8'h15, 4'h0);
    tk(8'h16, 4'h0);
    tk(8'h17, 4'h4);
    check("relock_status", {24'h0, uo_out}, 32'h48);

    // Wrap through FF -> 00.
    tk(8'hFD, 4'h2);
    tk(8'hFE, 4'h0);
    tk(8'hFF, 4'h0);
    tk(8'h00, 4'h0);
    tk(8'h01, 4'h4);
    check("wrap_status", {24'h0, uo_out}, 32'h4A);
    tk(8'h02, 4'h0);
    check("wrap_err0", {24'h0, uo_out}, 32'h00);

    // Saturation, then clear while staying in TRACK.
    for (int i = 0; i < 200; i++) tk(8'h33, 4'h0);
    check("err_saturate", {24'h0, uo_out}, 32'h7F);
    tk(8'h33, 4'h2);
    check("clear_err", {24'h0, uo_out}, 32'h00);
    tk(8'h34, 4'h4);
    check("clear_status", {24'h0, uo_out}, 32'h40);

    // Start with stop: stop wins, no load pulse; then a clean restart.
    tk(8'h35, 4'h9);
    check("stop_wins_strobe", {31'h0, uo_out[7]}, 32'h0);
    check("stop_wins_oe", {24'h0, uio_oe}, 32'h0);
    tk(8'h00, 4'h1);
    check("restart_oe", {24'h0, uio_oe}, 32'hFF);
    tk(8'h00, 4'h0);
    check("restart_oe_one_cycle", {24'h0, uio_oe}, 32'h0);
    tk(8'h00, 4'h0);
    tk(8'hA0, 4'h0);
    tk(8'hA1, 4'h0);

    // Reset mid-TRACK with a bad sample on the pins.
    rst_n = 1'b0;
    tk(8'h77, 4'h0);
    check("midreset_uo_out", {24'h0, uo_out}, 32'h0);
    check("midreset_uio_oe", {24'h0, uio_oe}, 32'h0);
    check("midreset_uio_out", {24'h0, uio_out}, 32'h0);
    rst_n = 1'b1;

    // Randomized run: mostly a clean counter stream with rare corruption and control.
    ctr = 8'h00;
    for (int i = 0; i < 4000; i++) begin
      r   = int'($urandom_range(0, 99));
      ctl = 4'h0;
      if (r == 0)      ctl = 4'h9;
      else if (r < 3)  ctl[0] = 1'b1;
      else if (r < 5)  ctl[3] = 1'b1;
      else if (r < 7)  ctl[1] = 1'b1;
      else             ctl = 4'h0;
      ctl[2] = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) seed_n = 4'($urandom_range(0, 15));
      rst_n = ($urandom_range(0, 299) != 0);
      ctr = ctr + 8'd1;
      if ($urandom_range(0, 63) == 0) ctr = 8'($urandom);
      if ($urandom_range(0, 15) == 0) tk(8'($urandom), ctl);
      else                            tk(ctr, ctl);
    end
    rst_n = 1'b1;
    tk(8'h00, 4'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
